// File: rtl/result_writeback.sv
// Write-back stage: steers ALU results into the PC or the output-number register.
// Optional PC_ALIGN_CHECK_EN drops misaligned PC writes and raises sticky misalign.
module result_writeback #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] result,
    input  logic             sel_dest,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] output_number,
    output logic             out_valid,
    input  logic             out_ack,
    output logic             misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic out_wr;
    logic pc_wr;
    logic pc_take;

    assign accept = in_valid && in_ready;
    assign out_wr = accept && !sel_dest;
    assign pc_wr  = accept && sel_dest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (out_wr) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ack && !out_wr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The stall is global: a pending output blocks PC writes too.
    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state == IDLE) || out_ack;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            output_number <= '0;
        end else if (out_wr) begin
            output_number <= result;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic pc_bad;

    assign pc_bad  = pc_wr && (result[1:0] != 2'b00);
    assign pc_take = pc_wr && !pc_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (pc_bad) begin
            misalign <= 1'b1;
        end
    end
`else
    assign pc_take  = pc_wr;
    assign misalign = 1'b0;
`endif

    // A taken write beats the increment; a dropped write lets it through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (pc_take) begin
            pc <= result;
        end else if (pc_inc) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Directed table-driven bench for result_writeback.
// Expected values follow PC_ALIGN_CHECK_EN when it is defined.
module tb_result_writeback;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        sel_dest;
    logic        pc_inc;
    logic [31:0] pc;
    logic [31:0] output_number;
    logic        out_valid;
    logic        out_ack;
    logic        misalign;

    int checks;
    int errors;

    result_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .result        (result),
        .sel_dest      (sel_dest),
        .pc_inc        (pc_inc),
        .pc            (pc),
        .output_number (output_number),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic        sd;
        logic        inc;
        logic        ack;
        logic        e_rdy;
        logic [31:0] e_pc;
        logic [31:0] e_on;
        logic        e_ov;
        logic        e_mis;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] res,
                         input logic sd, input logic inc, input logic ack);
        in_valid = iv;
        result   = res;
        sel_dest = sd;
        pc_inc   = inc;
        out_ack  = ack;
    endtask

    initial begin
        logic [31:0] p14;
        logic [31:0] p16;
        checks = 0;
        errors = 0;
        p14 = ALIGN ? 32'h100 : 32'h102;
        p16 = ALIGN ? 32'h204 : 32'h103;

        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0,
                    1'b1, 32'd4,         32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0,
                    1'b1, 32'd8,         32'h0,         1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0,
                    1'b1, 32'd12,        32'h0,         1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'd12,        32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h5,         1'b0, 1'b0, 1'b0,
                    1'b0, 32'd12,        32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h5,         1'b0, 1'b0, 1'b0,
                    1'b0, 32'd12,        32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h1,         1'b0, 1'b0, 1'b1,
                    1'b1, 32'd12,        32'h1,         1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h2,         1'b0, 1'b0, 1'b1,
                    1'b1, 32'd12,        32'h2,         1'b1, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1,
                    1'b1, 32'd12,        32'h2,         1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1,
                    1'b1, 32'd12,        32'h2,         1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0,
                    1'b1, 32'hFFFF_FFFC, 32'h2,         1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0,
                    1'b1, 32'h0,         32'h2,         1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h100,       1'b1, 1'b1, 1'b0,
                    1'b1, 32'h100,       32'h2,         1'b0, 1'b0};
        tbl[13] = '{1'b1, 32'h102,       1'b1, 1'b0, 1'b0,
                    1'b1, p14,           32'h2,         1'b0, ALIGN};
        tbl[14] = '{1'b1, 32'h200,       1'b1, 1'b0, 1'b0,
                    1'b1, 32'h200,       32'h2,         1'b0, ALIGN};
        tbl[15] = '{1'b1, 32'h103,       1'b1, 1'b1, 1'b0,
                    1'b1, p16,           32'h2,         1'b0, ALIGN};
        tbl[16] = '{1'b1, 32'hAA,        1'b0, 1'b0, 1'b0,
                    1'b1, p16,           32'hAA,        1'b1, ALIGN};
        tbl[17] = '{1'b1, 32'h300,       1'b1, 1'b0, 1'b0,
                    1'b0, p16,           32'hAA,        1'b1, ALIGN};
        tbl[18] = '{1'b1, 32'h300,       1'b1, 1'b0, 1'b1,
                    1'b1, 32'h300,       32'hAA,        1'b0, ALIGN};

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst pc",       pc,                    32'h0);
        chk("rst out_num",  output_number,         32'h0);
        chk("rst out_val",  {31'b0, out_valid},    32'h0);
        chk("rst in_ready", {31'b0, in_ready},     32'h1);
        chk("rst misalign", {31'b0, misalign},     32'h0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].res, tbl[i].sd, tbl[i].inc, tbl[i].ack);
            #1;
            chk($sformatf("row%0d in_ready", i), {31'b0, in_ready},
                {31'b0, tbl[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("row%0d out_num", i), output_number, tbl[i].e_on);
            chk($sformatf("row%0d out_val", i), {31'b0, out_valid},
                {31'b0, tbl[i].e_ov});
            chk($sformatf("row%0d misalign", i), {31'b0, misalign},
                {31'b0, tbl[i].e_mis});
        end

        // Async reset while HOLD: clears before any further clock edge.
        drive(1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("hold out_val", {31'b0, out_valid}, 32'h1);
        chk("hold out_num", output_number, 32'h7);
        #2 reset = 1'b1;
        #1;
        chk("async out_val",  {31'b0, out_valid}, 32'h0);
        chk("async pc",       pc,                 32'h0);
        chk("async out_num",  output_number,      32'h0);
        chk("async misalign", {31'b0, misalign},  32'h0);
        chk("async in_ready", {31'b0, in_ready},  32'h1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Wrap of pc via increment from a freshly written top value.
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap pc0", pc, 32'h0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap pc4", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
